adc_serial_rx: RTL and testbench

- Upstream capture stage of the ADC→DAC sample path.
- Drives chip-select for a 12-bit serial ADC framed as 4 leading zeros + 12 data bits, MSB first, 16 bits total.
- Deserialises each frame on CLK1MHz, which also serves as the ADC serial clock.
- Presents a held 12-bit sample plus a one-cycle ready strobe to the downstream parallel-to-serial DAC sender.

---
 rtl/adc_serial_rx_pkg.sv | 22 ++
 rtl/adc_serial_rx.sv | 112 +++++++++++
 tb/tb_adc_serial_rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_serial_rx_pkg.sv
// Shared constants for the serial ADC capture block: frame geometry,
// FSM state encoding and the DAC command nibble.
package adc_serial_rx_pkg;

  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_W   = 12;
  localparam int HDR_W      = FRAME_BITS - SAMPLE_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CONV = ST_CONV,
    DONE = ST_DONE
  } state_t;

  // Leading nibble of the DAC "write-and-update" command word.
  localparam logic [HDR_W-1:0] DAC_CMD = 4'b0000;

endpackage

// File: rtl/adc_serial_rx.sv
// Serial ADC receiver: drives CSn, deserialises a 16-bit frame
// (header zeros + DATA_W data bits, MSB first) on CLK1MHz and presents a
// held sample with a one-cycle DatoListo strobe.
// Optional build macro PACK_DAC_WORD_EN adds the DinDAC output carrying
// the ready-to-send 16-bit DAC command word.
module adc_serial_rx
  import adc_serial_rx_pkg::*;
#(
  parameter int QUIET_CYC = 4,
  parameter int DATA_W    = 12
) (
  input  logic              CLK1MHz,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              SData,
  output logic              CSn,
  output logic [DATA_W-1:0] Dato,
  output logic              DatoListo,
`ifdef PACK_DAC_WORD_EN
  output logic [15:0]       DinDAC,
`endif
  output logic              FrameError
);

  localparam logic [3:0] QUIET_LAST = 4'(QUIET_CYC - 1);
  localparam logic [3:0] BIT_LAST   = 4'(FRAME_BITS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              qcnt;
  logic [3:0]              bcnt;
  // Only the 15 most recent bits are ever needed: the 16th arrives on SData
  // in the capture cycle itself.
  logic [FRAME_BITS-2:0]   shift;
  logic [FRAME_BITS-1:0]   frame_word;

  // Any 1 in the header marks a misaligned or corrupted frame.
  function automatic logic header_error(input logic [FRAME_BITS-1:0] w);
    return |w[FRAME_BITS-1:DATA_W];
  endfunction

  assign frame_word = {shift, SData};

  // State register.
  always_ff @(posedge CLK1MHz) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    state_nxt = state;
    CSn       = 1'b1;
    DatoListo = 1'b0;
    case (state)
      IDLE: begin
        if (qcnt == QUIET_LAST && Enable) state_nxt = CONV;
      end
      CONV: begin
        CSn = 1'b0;
        if (bcnt == BIT_LAST) state_nxt = DONE;
      end
      DONE: begin
        DatoListo = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Quiet/bit counters, shift register and the held sample outputs.
  always_ff @(posedge CLK1MHz) begin
    if (Reset) begin
      qcnt       <= '0;
      bcnt       <= '0;
      shift      <= '0;
      Dato       <= '0;
      FrameError <= 1'b0;
`ifdef PACK_DAC_WORD_EN
      DinDAC     <= 16'h0000;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Saturates so a stalled (Enable=0) idle can restart immediately.
          if (qcnt != QUIET_LAST) qcnt <= qcnt + 4'd1;
          if (state_nxt == CONV)  bcnt <= '0;
        end
        CONV: begin
          shift <= frame_word[FRAME_BITS-2:0];
          if (bcnt == BIT_LAST) begin
            bcnt       <= '0;
            Dato       <= frame_word[DATA_W-1:0];
            FrameError <= header_error(frame_word);
`ifdef PACK_DAC_WORD_EN
            DinDAC     <= {DAC_CMD, frame_word[SAMPLE_W-1:0]};
`endif
          end else begin
            bcnt <= bcnt + 4'd1;
          end
        end
        DONE: begin
          qcnt <= '0;
        end
        default: begin
          qcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: an ADC model serves queued/random frames while
// a monitor compares every DatoListo strobe against a scoreboard queue and
// checks that outputs hold between strobes.
module tb_adc_serial_rx;

  localparam int QUIET_CYC = 4;
  localparam int DATA_W    = 12;
  localparam int PERIOD    = QUIET_CYC + 16 + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic              sdata = 1'b0;
  logic              csn;
  logic [DATA_W-1:0] dato;
  logic              listo;
  logic              ferr;
`ifdef PACK_DAC_WORD_EN
  logic [15:0]       dindac;
`endif

  adc_serial_rx #(.QUIET_CYC(QUIET_CYC), .DATA_W(DATA_W)) dut (
    .CLK1MHz   (clk),
    .Reset     (rst),
    .Enable    (en),
    .SData     (sdata),
    .CSn       (csn),
    .Dato      (dato),
    .DatoListo (listo),
`ifdef PACK_DAC_WORD_EN
    .DinDAC    (dindac),
`endif
    .FrameError(ferr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0]       stim_q[$];
  logic [DATA_W:0]   exp_q[$];   // {frame_error, sample}

  int cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ADC model: while CSn is low, present one frame bit per cycle MSB first.
  int          idx = 0;
  logic [15:0] cur = 16'h0;
  always @(negedge clk) begin
    if (csn !== 1'b0) begin
      idx   = 0;
      sdata = 1'($urandom);
    end else begin
      if (idx == 0) cur = (stim_q.size() != 0) ? stim_q.pop_front() : 16'($urandom);
      sdata = cur[15-idx];
      if (idx == 15) exp_q.push_back({(cur[15:DATA_W] != 0), cur[DATA_W-1:0]});
      idx = (idx + 1) % 16;
    end
  end

  // Monitor: compare strobes against the scoreboard, check holding otherwise.
  logic [DATA_W-1:0] hold_d = '0;
  logic              hold_e = 1'b0;
  logic [DATA_W:0]   e;
  int                strobes = 0;
  int                last_cyc = 0;
  bit                prev_valid = 0;
  bit                period_chk = 0;
  always @(negedge clk) begin
    if (rst_seen) begin
      chk("reset_csn", csn, 1);
      chk("reset_listo", listo, 0);
      chk("reset_dato", dato, 0);
      chk("reset_ferr", ferr, 0);
`ifdef PACK_DAC_WORD_EN
      chk("reset_dindac", dindac, 0);
`endif
      hold_d = '0;
      hold_e = 1'b0;
      prev_valid = 0;
      exp_q.delete();
    end else if (listo === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_dato", dato, e[DATA_W-1:0]);
        chk("strobe_ferr", ferr, e[DATA_W]);
`ifdef PACK_DAC_WORD_EN
        chk("strobe_dindac", dindac, {4'h0, e[DATA_W-1:0]});
`endif
        hold_d = e[DATA_W-1:0];
        hold_e = e[DATA_W];
      end
      if (period_chk && prev_valid) chk("strobe_period", cyc - last_cyc, PERIOD);
      prev_valid = period_chk;
      last_cyc   = cyc;
    end else begin
      chk("hold_dato", dato, hold_d);
      chk("hold_ferr", ferr, hold_e);
`ifdef PACK_DAC_WORD_EN
      chk("hold_dindac", dindac, {4'h0, hold_d});
`endif
    end
  end

  task automatic wait_strobes(input int target, input int limit);
    int n = 0;
    while (strobes < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (strobes < target) chk("strobe_timeout", strobes, target);
  endtask

  task automatic wait_csn_fall(input int limit);
    int n = 0;
    @(negedge clk);
    while (csn !== 1'b1 && n < limit) begin @(negedge clk); n++; end
    while (csn !== 1'b0 && n < limit) begin @(negedge clk); n++; end
    if (csn !== 1'b0) chk("csn_fall_timeout", csn, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [15:0] w;
    // Reset held 3 cycles with Enable already high: reset must win.
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    stim_q.push_back(16'h0ABC);
    stim_q.push_back(16'h8FFF);
    stim_q.push_back(16'h0001);
    stim_q.push_back(16'h0800);
    stim_q.push_back(16'h0FFF);
    period_chk = 1;
    #2 rst = 1'b0;

    // Frame timing from release: 4 quiet cycles, 16 CONV, strobe on 21.
    for (int i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      chk($sformatf("init_csn_c%0d", i), csn, (i > QUIET_CYC && i < PERIOD) ? 0 : 1);
      chk($sformatf("init_listo_c%0d", i), listo, (i == PERIOD) ? 1 : 0);
    end
    wait_strobes(5, 5 * PERIOD + 10);

    // Random back-to-back frames, some with corrupt headers.
    repeat (8) begin
      if ($urandom_range(0, 3) == 0) w = 16'($urandom);
      else                           w = {4'h0, 12'($urandom)};
      stim_q.push_back(w);
    end
    wait_strobes(strobes + 8, 8 * PERIOD + 10);

    // Drop Enable mid-frame: the frame completes, then the bus stays idle.
    period_chk = 0;
    wait_csn_fall(3 * PERIOD);
    repeat (5) @(posedge clk);
    #2 en = 1'b0;
    s = strobes;
    wait_strobes(s + 1, 2 * PERIOD);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("disabled_csn", csn, 1);
    end
    @(posedge clk);
    #2 en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reenable_conv_next_cycle", csn, 0);
    period_chk = 1;
    s = strobes;
    wait_strobes(s + 2, 3 * PERIOD);

    // Reset pulse in the middle of a conversion.
    period_chk = 0;
    wait_csn_fall(3 * PERIOD);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("midconv_reset_csn", csn, 1);
    stim_q.delete();
    stim_q.push_back(16'h0A5A);
    s = strobes;
    wait_strobes(s + 1, 2 * PERIOD + 10);
    @(posedge clk);
    #1 chk("post_reset_frame", dato, 12'hA5A);
    chk("post_reset_ferr", ferr, 0);

    en = 1'b0;
    repeat (2 * PERIOD) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
